// File: rtl/ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx
// Purpose  : PS/2 keyboard receiver. Synchronises the raw PS/2 clock/data
//            lines, deserialises 11-bit frames (start, D0..D7 LSB first, odd
//            parity, stop), validates them, and queues good scancodes in a
//            first-word-fall-through FIFO read over a valid/ready handshake.
// Ports    : clk        in   system clock
//            rst        in   asynchronous active-low reset (0 = reset)
//            ps2_clk    in   raw PS/2 clock (asynchronous)
//            ps2_data   in   raw PS/2 data (asynchronous)
//            data       out  [7:0] scancode at FIFO head
//            valid      out  FIFO non-empty
//            ready      in   consumer accepts data this cycle
//            count      out  [$clog2(DEPTH):0] bytes buffered
//            overflow   out  sticky: good frame dropped on a full FIFO
//            frame_err  out  one-cycle pulse: bad / aborted frame discarded
// Params   : DEPTH (power of 2, >= 2), TIMEOUT_CYCLES
// Options  : define PS2_RX_TIMEOUT_EN to abort partial frames after
//            TIMEOUT_CYCLES idle clocks; otherwise a partial frame waits.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ps2_clk,
  input  logic                   ps2_data,
  output logic [7:0]             data,
  output logic                   valid,
  input  logic                   ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   frame_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // --------------------------------------------------------------------------
  // Input synchronisers. Reset to 1 so an idle bus produces no false edge.
  // The third clock stage provides the "previous" value for edge detection.
  // --------------------------------------------------------------------------
  logic r_clk_s1, r_clk_s2, r_clk_s3;
  logic r_dat_s1, r_dat_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_s3 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_clk_s3 <= r_clk_s2;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  logic w_fall;
  assign w_fall = r_clk_s3 & ~r_clk_s2;

  // --------------------------------------------------------------------------
  // Deserialiser. Bits shift in from the top, so after ten edges r_frame[0]
  // holds the start bit, [8:1] the byte and [9] the parity. The stop bit is
  // taken straight from the synchroniser on the eleventh edge.
  // --------------------------------------------------------------------------
  logic [3:0] r_bitcnt;
  logic [9:0] r_frame;
  logic       w_last;
  logic       w_good;
  logic       w_push;
  logic       w_bad;
  logic       w_timeout;
  logic [7:0] w_byte;

  assign w_last = w_fall && (r_bitcnt == 4'd10);
  assign w_good = ~r_frame[0] & r_dat_s2 & (^r_frame[9:1]);
  assign w_byte = r_frame[8:1];
  assign w_push = w_last & w_good;
  assign w_bad  = w_last & ~w_good;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] r_idle;

  // Counts clocks since the last edge while a frame is in progress.
  assign w_timeout = (r_bitcnt != 4'd0) && !w_fall &&
                     (r_idle == IW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idle <= '0;
    end else if (w_fall || (r_bitcnt == 4'd0) || w_timeout) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bitcnt <= 4'd0;
      r_frame  <= '0;
    end else if (w_timeout) begin
      r_bitcnt <= 4'd0;
    end else if (w_fall) begin
      r_frame  <= {r_dat_s2, r_frame[9:1]};
      r_bitcnt <= (r_bitcnt == 4'd10) ? 4'd0 : r_bitcnt + 4'd1;
    end
  end

  logic r_frame_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_bad | w_timeout;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO. The head is held in a separate output register so that data keeps
  // its last value once the FIFO drains, rather than showing stale storage.
  // --------------------------------------------------------------------------
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] w_rnext;
  logic [CW-1:0] r_count;
  logic [7:0]    r_data;
  logic          r_overflow;
  logic          w_valid;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = w_valid & ready;
  // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;
  assign w_rnext = r_rptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_byte;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= w_rnext;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Head register update: after a pop the next stored entry moves up; a
  // byte written into an empty (or emptying) FIFO becomes the head directly,
  // since it is not yet readable from storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= 8'h00;
    end else if (w_pop && (r_count > CW'(1))) begin
      r_data <= r_mem[w_rnext];
    end else if (w_wr && ((r_count == '0) || ((r_count == CW'(1)) && w_pop))) begin
      r_data <= w_byte;
    end
  end

  assign data      = r_data;
  assign valid     = w_valid;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_rx
// Purpose  : Self-checking bench for ps2_kbd_rx. Stimulus pushes expected
//            scancodes into a queue; a monitor pops and compares on every
//            valid && ready cycle and tallies frame_err pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       ready = 1'b0;
  logic [3:0] count;
  logic       overflow;
  logic       frame_err;

  ps2_kbd_rx #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .count     (count),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         err_seen = 0;
  int         exp_err = 0;
  int         pops = 0;
  logic [7:0] exp_q[$];

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) err_seen++;
      if (valid && ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pop: got 0x%0h expected none", data);
        end else begin
          check("pop_data", {24'h0, data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  function automatic logic [10:0] mk(input logic [7:0] b, input logic bad_par,
                                     input logic bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    @(posedge clk); #2 ps2_data = b;
    repeat (4) @(posedge clk);
    #2 ps2_clk = 1'b0;
    repeat (5) @(posedge clk);
    #2 ps2_clk = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) ps2_bit(f[i]);
  endtask

  task automatic wait_drain(input string nm);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_drain_timeout: got %0d pending expected 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2 rst = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int pops0;
    // ---------------- reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", {24'h0, data}, 32'h00);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_count", {28'h0, count}, 32'h0);
    check("rst_overflow", {31'h0, overflow}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);

    // ---------------- single good frame, consumer ready
    #2 ready = 1'b1;
    pops0 = pops;
    exp_q.push_back(8'h1C);
    send_bits(mk(8'h1C, 1'b0, 1'b0), 11);
    wait_drain("t1");
    check("t1_pop_count", pops - pops0, 1);
    check("t1_valid_low", {31'h0, valid}, 32'h0);
    check("t1_count", {28'h0, count}, 32'h0);
    check("t1_err", err_seen, exp_err);

    // ---------------- bad parity, then bad stop
    pops0 = pops;
    send_bits(mk(8'h1C, 1'b1, 1'b0), 11);
    exp_err++;
    repeat (10) @(posedge clk);
    check("t2_par_err", err_seen, exp_err);
    send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
    exp_err++;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t2_stop_err", err_seen, exp_err);
    check("t2_no_pop", pops - pops0, 0);
    check("t2_valid", {31'h0, valid}, 32'h0);

    // ---------------- overflow: nine frames into an eight-deep FIFO
    @(posedge clk); #2 ready = 1'b0;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      if (i <= DEPTH) exp_q.push_back(8'(i));
      send_bits(mk(8'(i), 1'b0, 1'b0), 11);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t3_count_full", {28'h0, count}, DEPTH);
    check("t3_overflow", {31'h0, overflow}, 32'h1);
    check("t3_head", {24'h0, data}, 32'h01);
    @(posedge clk); #2 ready = 1'b1;
    wait_drain("t3");
    @(negedge clk);
    check("t3_count_empty", {28'h0, count}, 32'h0);
    check("t3_overflow_sticky", {31'h0, overflow}, 32'h1);
    check("t3_err", err_seen, exp_err);

    // ---------------- reset in the middle of a frame
    @(posedge clk); #2 ready = 1'b0;
    exp_q.push_back(8'h33);
    send_bits(mk(8'h33, 1'b0, 1'b0), 11);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t4_pre_count", {28'h0, count}, 32'h1);
    send_bits(mk(8'hAA, 1'b0, 1'b0), 6);
    @(posedge clk); #2 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t4_rst_data", {24'h0, data}, 32'h00);
    check("t4_rst_valid", {31'h0, valid}, 32'h0);
    check("t4_rst_count", {28'h0, count}, 32'h0);
    check("t4_rst_overflow", {31'h0, overflow}, 32'h0);
    check("t4_rst_frame_err", {31'h0, frame_err}, 32'h0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    ready = 1'b1;
    repeat (2) @(posedge clk);
    pops0 = pops;
    exp_q.push_back(8'hF0);
    send_bits(mk(8'hF0, 1'b0, 1'b0), 11);
    wait_drain("t4");
    check("t4_pop_count", pops - pops0, 1);
    check("t4_err", err_seen, exp_err);

    // ---------------- full FIFO, push lands in a pop cycle
    do_reset();
    #2 ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8'h10 + 8'(i));
      send_bits(mk(8'h10 + 8'(i), 1'b0, 1'b0), 11);
    end
    repeat (3) @(posedge clk);
    exp_q.push_back(8'h18);
    begin
      logic [10:0] f;
      f = mk(8'h18, 1'b0, 1'b0);
      send_bits(f, 10);
      @(posedge clk); #2 ps2_data = f[10];
      repeat (4) @(posedge clk);
      #2 ps2_clk = 1'b0;
      // Falling edge is seen two clocks later; the push happens on the next.
      @(posedge clk);
      @(posedge clk);
      #2 ready = 1'b1;
      @(posedge clk);
      #2 ready = 1'b0;
      repeat (3) @(posedge clk);
      #2 ps2_clk = 1'b1;
      repeat (4) @(posedge clk);
    end
    @(negedge clk);
    check("t5_count", {28'h0, count}, DEPTH);
    check("t5_overflow", {31'h0, overflow}, 32'h0);
    check("t5_head", {24'h0, data}, 32'h11);
    @(posedge clk); #2 ready = 1'b1;
    wait_drain("t5");
    check("t5_err", err_seen, exp_err);

    // ---------------- partial frame, long idle, then a full 0x5A frame
    send_bits(11'h7FF, 4);
    repeat (120) @(posedge clk);
`ifdef PS2_RX_TIMEOUT_EN
    exp_q.push_back(8'h5A);
`endif
    send_bits(mk(8'h5A, 1'b0, 1'b0), 11);
    exp_err++;
    wait_drain("t6");
    @(negedge clk);
    check("t6_err", err_seen, exp_err);
    check("t6_count", {28'h0, count}, 32'h0);
    check("t6_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
